// File: rtl/c1_pkg.sv
// Shared types and constants for the 1-D diffusion kernel.
package c1_pkg;

   localparam int W         = 32;
   localparam int DEPTH_DEF = 32;
   localparam int ITERS_DEF = 8;
   localparam int SHIFT_DEF = 2;
   localparam logic [W-1:0] AMP_DEF = 32'h00010000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_SWEEP,
      ST_DONE
   } state_t;

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int c1_log2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/c1_stencil_cell.sv
// Combinational explicit-diffusion update of one interior cell.
module c1_stencil_cell
   import c1_pkg::*;
#(
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic signed [W-1:0] i_left,
   input  logic signed [W-1:0] i_centre,
   input  logic signed [W-1:0] i_right,
   output logic signed [W-1:0] o_value
);

   logic signed [W+1:0] w_l;
   logic signed [W+1:0] w_c;
   logic signed [W+1:0] w_r;
   logic signed [W+1:0] w_lap;
   logic signed [W+1:0] w_sh;

   // Two guard bits keep l - 2c + r exact before the floor shift.
   assign w_l   = {{2{i_left[W-1]}},   i_left};
   assign w_c   = {{2{i_centre[W-1]}}, i_centre};
   assign w_r   = {{2{i_right[W-1]}},  i_right};
   assign w_lap = w_l - (w_c <<< 1) + w_r;
   assign w_sh  = w_lap >>> SHIFT;

   assign o_value = i_centre + $signed(w_sh[W-1:0]);

endmodule

// File: rtl/c1_kernel.sv
// Run controller, ping-pong field banks and checksum accumulator for ITERS Jacobi sweeps.
module c1_kernel
   import c1_pkg::*;
#(
   parameter int           DEPTH = DEPTH_DEF,
   parameter int           ITERS = ITERS_DEF,
   parameter int           SHIFT = SHIFT_DEF,
   parameter logic [W-1:0] AMP   = AMP_DEF
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         ce,
   input  logic         i_run_req,
   output logic         o_run_busy,
   output logic [W-1:0] o_checksum,
   output logic         o_done
);

   localparam int IW = c1_log2(DEPTH);
   localparam int KW = c1_log2(ITERS + 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);
   localparam logic [IW-1:0] IDX_MID   = IW'(DEPTH / 2);
   localparam logic [KW-1:0] ITER_ONE  = KW'(1);
   localparam logic [KW-1:0] ITER_LAST = KW'(ITERS - 1);

   state_t r_state;
   state_t w_next;

   logic [IW-1:0] r_idx;
   logic [KW-1:0] r_iter;
   logic          r_src_b;
   logic [W-1:0]  r_acc;

   logic signed [W-1:0] r_bank_a [DEPTH];
   logic signed [W-1:0] r_bank_b [DEPTH];

   logic [IW-1:0]       w_idx_m1;
   logic [IW-1:0]       w_idx_p1;
   logic                w_idx_last;
   logic                w_last_sweep;
   logic                w_edge;
   logic signed [W-1:0] w_left;
   logic signed [W-1:0] w_centre;
   logic signed [W-1:0] w_right;
   logic signed [W-1:0] w_cell;
   logic signed [W-1:0] w_new;

   assign w_idx_m1     = r_idx - IDX_ONE;
   assign w_idx_p1     = r_idx + IDX_ONE;
   assign w_idx_last   = (r_idx == IDX_LAST);
   assign w_last_sweep = (r_iter == ITER_LAST);
   assign w_edge       = (r_idx == '0) || w_idx_last;

   // Neighbour reads wrap at the ends; those values are discarded by the boundary mux.
   assign w_left   = r_src_b ? r_bank_b[w_idx_m1] : r_bank_a[w_idx_m1];
   assign w_centre = r_src_b ? r_bank_b[r_idx]    : r_bank_a[r_idx];
   assign w_right  = r_src_b ? r_bank_b[w_idx_p1] : r_bank_a[w_idx_p1];

   c1_stencil_cell #(
      .SHIFT (SHIFT)
   ) u_cell (
      .i_left   (w_left),
      .i_centre (w_centre),
      .i_right  (w_right),
      .o_value  (w_cell)
   );

   assign w_new = w_edge ? w_centre : w_cell;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (i_run_req) w_next = ST_INIT;
         ST_INIT:  if (w_idx_last) w_next = ST_SWEEP;
         ST_SWEEP: if (w_idx_last && w_last_sweep) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_iter     <= '0;
         r_src_b    <= 1'b0;
         r_acc      <= '0;
         o_run_busy <= 1'b0;
         o_done     <= 1'b0;
         o_checksum <= '0;
      end else if (ce) begin
         r_state <= w_next;
         o_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_run_req) begin
                  o_run_busy <= 1'b1;
                  r_idx      <= '0;
                  r_iter     <= '0;
                  r_src_b    <= 1'b0;
                  r_acc      <= '0;
               end
            end
            ST_INIT: r_idx <= w_idx_p1;
            ST_SWEEP: begin
               r_idx <= w_idx_p1;
               if (w_last_sweep) r_acc <= r_acc + $unsigned(w_new);
               if (w_idx_last) begin
                  r_iter  <= r_iter + ITER_ONE;
                  r_src_b <= ~r_src_b;
               end
            end
            ST_DONE: begin
               o_checksum <= r_acc;
               o_run_busy <= 1'b0;
               o_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Field contents need no reset; INIT rewrites bank A before any read.
   always_ff @(posedge clock) begin
      if (ce) begin
         if (r_state == ST_INIT) begin
            r_bank_a[r_idx] <= (r_idx == IDX_MID) ? $signed(AMP) : '0;
         end else if (r_state == ST_SWEEP) begin
            if (r_src_b) r_bank_a[r_idx] <= w_new;
            else         r_bank_b[r_idx] <= w_new;
         end
      end
   end

endmodule

// File: tb/tb_c1_kernel.sv
// Directed checks of run latency, checksum, ce gating, ignored requests and reset for c1_kernel.
module tb_c1_kernel;
   import c1_pkg::*;

   localparam int NONE = 100000;
   // Impulse of 2^16 divides exactly through 8 quarter-steps and never reaches the ends: sum is conserved.
   localparam logic [31:0] CSUM_NOM = 32'h00010000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic        run_req = 1'b0;
   logic        run_req1 = 1'b0;
   logic        busy, done, busy1, done1;
   logic [31:0] csum, csum1;

   int n_checks = 0;
   int n_fail   = 0;
   int b, d, n1;

   always #5 clock = ~clock;

   c1_kernel dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ce         (ce),
      .i_run_req  (run_req),
      .o_run_busy (busy),
      .o_checksum (csum),
      .o_done     (done)
   );

   c1_kernel #(.ITERS(1)) dut1 (
      .clock      (clock),
      .reset_n    (reset_n),
      .ce         (ce),
      .i_run_req  (run_req1),
      .o_run_busy (busy1),
      .o_checksum (csum1),
      .o_done     (done1)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one request, then follow the run; c numbers the samples with busy high.
   task automatic do_run(input int gate_at, input int req_at, input int rst_at,
                         output int busy_cyc, output int dones);
      int c;
      busy_cyc = 0;
      dones    = 0;
      c        = 0;
      run_req  = 1'b1;
      tick();
      run_req  = 1'b0;
      while (busy === 1'b1 && c < 1000) begin
         busy_cyc++;
         c++;
         ce      = !(c >= gate_at && c < gate_at + 10);
         run_req = (c == req_at);
         if (c == rst_at) begin
            reset_n = 1'b0;
            #1;
            chk("rst_mid_busy", 32'(busy), 32'd0);
            chk("rst_mid_csum", csum, 32'd0);
            run_req = 1'b0;
            ce      = 1'b1;
            return;
         end
         tick();
         if (done) dones++;
      end
      run_req = 1'b0;
      ce      = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #100;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_csum", csum, 32'd0);
      reset_n = 1'b1;
      tick();

      // ITERS=1 instance: one sweep spreads the impulse to its neighbours
      run_req1 = 1'b1;
      tick();
      run_req1 = 1'b0;
      n1 = 0;
      while (busy1 === 1'b1 && n1 < 1000) begin
         n1++;
         tick();
      end
      chk("it1_busy", 32'(n1), 32'd65);
      chk("it1_csum", csum1, 32'd65536);
      chk("it1_cell14", dut1.r_bank_b[14], 32'd0);
      chk("it1_cell15", dut1.r_bank_b[15], 32'd16384);
      chk("it1_cell16", dut1.r_bank_b[16], 32'd32768);
      chk("it1_cell17", dut1.r_bank_b[17], 32'd16384);
      chk("it1_cell18", dut1.r_bank_b[18], 32'd0);

      do_run(NONE, NONE, NONE, b, d);
      chk("nom_busy", 32'(b), 32'd289);
      chk("nom_done_cnt", 32'(d), 32'd1);
      chk("nom_done_at_fall", 32'(done), 32'd1);
      chk("nom_csum", csum, CSUM_NOM);

      // request on the first idle sample, one cycle after busy fell
      do_run(NONE, NONE, NONE, b, d);
      chk("b2b_busy", 32'(b), 32'd289);
      chk("b2b_done_cnt", 32'(d), 32'd1);
      chk("b2b_csum", csum, CSUM_NOM);
      tick();
      chk("done_clears", 32'(done), 32'd0);

      do_run(100, NONE, NONE, b, d);
      chk("gate_busy", 32'(b), 32'd299);
      chk("gate_done_cnt", 32'(d), 32'd1);
      chk("gate_csum", csum, CSUM_NOM);

      do_run(NONE, 50, NONE, b, d);
      chk("reqbusy_busy", 32'(b), 32'd289);
      repeat (5) tick();
      chk("reqbusy_no_rerun", 32'(busy), 32'd0);

      // sample 289 is the DONE cycle
      do_run(NONE, 289, NONE, b, d);
      chk("reqdone_busy", 32'(b), 32'd289);
      repeat (5) tick();
      chk("reqdone_no_rerun", 32'(busy), 32'd0);

      do_run(NONE, NONE, 100, b, d);
      chk("rst_mid_at", 32'(b), 32'd100);
      tick();
      tick();
      chk("rst_held_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      tick();
      do_run(NONE, NONE, NONE, b, d);
      chk("after_rst_busy", 32'(b), 32'd289);
      chk("after_rst_csum", csum, CSUM_NOM);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
